// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage.
//   LEGV8_INTEGER_SZ / LEGV8_INSTRUCTION_SZ : datapath and instruction widths
//   PC_STEP_DEFAULT                          : default sequential PC increment
//   fetch_state_e                            : fetch sequencer states
//   pc_op_e                                  : PC-unit update command issued by the sequencer
//   align_target()                           : clears the low two bits of a redirect target
package fetch_pkg;

  localparam int unsigned LEGV8_INTEGER_SZ     = 64;
  localparam int unsigned LEGV8_INSTRUCTION_SZ = 32;

  typedef logic [LEGV8_INTEGER_SZ-1:0]     addr_t;
  typedef logic [LEGV8_INSTRUCTION_SZ-1:0] inst_t;

  localparam addr_t PC_STEP_DEFAULT = addr_t'(4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,  // no change
    PC_LOAD   = 3'd1,  // pc <= target
    PC_INC    = 3'd2,  // pc <= pc + PC_STEP
    PC_ARM    = 3'd3,  // kill <= 1, redir_pc <= target, pc held
    PC_RESUME = 3'd4   // pc <= redirect ? target : redir_pc, kill <= 0
  } pc_op_e;

  function automatic addr_t align_target(input addr_t a);
    return a & ~addr_t'(3);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: instruction-memory and decode handshakes of the fetch stage.
//   imem_req/imem_addr  : request to instruction memory (addr stable while req=1)
//   imem_ack/imem_data  : one-cycle response per request
//   inst_valid/inst/inst_pc/dec_ready : valid/ready hand-off to decode
// Modports: master = fetch controller side, slave = memory/decode side.
interface fetch_controller_if;
  import fetch_pkg::*;

  logic  imem_req;
  addr_t imem_addr;
  logic  imem_ack;
  inst_t imem_data;
  logic  inst_valid;
  inst_t inst;
  addr_t inst_pc;
  logic  dec_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_data, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_data, dec_ready
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: architectural PC, pending-redirect register and kill flag.
//   clk, reset   : clock, asynchronous active-high reset
//   pc_op_i      : update command from the sequencer
//   redirect_i   : redirect asserted this cycle (selects target on PC_RESUME)
//   new_pc_i     : raw redirect target (aligned here)
//   pc_o         : current fetch PC
//   kill_o       : an outstanding request must be discarded on its ack
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = '0,
  parameter addr_t PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  pc_op_e pc_op_i,
  input  logic   redirect_i,
  input  addr_t  new_pc_i,
  output addr_t  pc_o,
  output logic   kill_o
);

  addr_t pc_q, pc_d;
  addr_t redir_q, redir_d;
  logic  kill_q, kill_d;
  addr_t target;

  assign target = align_target(new_pc_i);

  always_comb begin
    pc_d    = pc_q;
    redir_d = redir_q;
    kill_d  = kill_q;
    case (pc_op_i)
      PC_LOAD: pc_d = target;
      PC_INC:  pc_d = pc_q + PC_STEP;  // wraps modulo 2^64
      PC_ARM: begin
        // pc stays put so the in-flight address is stable; last redirect wins
        kill_d  = 1'b1;
        redir_d = target;
      end
      PC_RESUME: begin
        pc_d   = redirect_i ? target : redir_q;
        kill_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      redir_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      redir_q <= redir_d;
      kill_q  <= kill_d;
    end
  end

  assign pc_o   = pc_q;
  assign kill_o = kill_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: fetch-stage sequencer. Owns the PC, issues one
// instruction-memory request at a time and hands each fetched word to decode.
// Branch redirects are applied immediately, or deferred via kill/redir_pc
// when a request is in flight.
//   clk, reset                 : clock, asynchronous active-high reset
//   fetch_en                   : allow new requests (0 drains to idle)
//   branch_flag, zero_flag     : conditional redirect when both set
//   uncond_branch_flag         : unconditional redirect
//   new_pc                     : redirect target (low 2 bits ignored)
//   bus (master)               : imem req/ack and decode valid/ready handshakes
//   pc                         : current fetch PC (== bus.imem_addr)
//   perf_fetched/perf_flushed  : saturating counters, only with FETCH_PERF_CNT_EN
module fetch_controller
  import fetch_pkg::*;
#(
  parameter addr_t RESET_PC = '0,
  parameter addr_t PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_en,
  input  logic                      branch_flag,
  input  logic                      uncond_branch_flag,
  input  logic                      zero_flag,
  input  addr_t                     new_pc,
  fetch_controller_if.master        bus,
  output addr_t                     pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]               perf_fetched,
  output logic [31:0]               perf_flushed
`endif
);

  fetch_state_e state_q;
  logic         req_q;
  logic         valid_q;
  inst_t        inst_q;
  addr_t        inst_pc_q;

  logic   redirect;
  logic   kill;
  logic   discard;
  pc_op_e pc_op;
  addr_t  pc_w;

  assign redirect = (branch_flag & zero_flag) | uncond_branch_flag;
  assign discard  = kill | redirect;

  always_comb begin
    pc_op = PC_HOLD;
    case (state_q)
      S_IDLE: if (redirect) pc_op = PC_LOAD;
      S_REQ: begin
        if (bus.imem_ack)   pc_op = discard ? PC_RESUME : PC_INC;
        else if (redirect)  pc_op = PC_ARM;
      end
      S_HOLD: if (redirect) pc_op = PC_LOAD;
      default: pc_op = PC_HOLD;
    endcase
  end

  fetch_pc_unit #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .pc_op_i    (pc_op),
    .redirect_i (redirect),
    .new_pc_i   (new_pc),
    .pc_o       (pc_w),
    .kill_o     (kill)
  );

  // req_q tracks entry into S_REQ so imem_req comes straight from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_en) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_REQ: begin
          if (bus.imem_ack) begin
            if (discard) begin
              state_q <= fetch_en ? S_REQ : S_IDLE;
              req_q   <= fetch_en;
            end else begin
              inst_q    <= bus.imem_data;
              inst_pc_q <= pc_w;
              valid_q   <= 1'b1;
              req_q     <= 1'b0;
              state_q   <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect || bus.dec_ready) begin
            valid_q <= 1'b0;
            state_q <= fetch_en ? S_REQ : S_IDLE;
            req_q   <= fetch_en;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_w;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign pc             = pc_w;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;
  logic        xfer_evt;
  logic        flush_evt;

  assign xfer_evt  = (state_q == S_HOLD) & bus.dec_ready & ~redirect;
  assign flush_evt = ((state_q == S_REQ) & bus.imem_ack & discard) |
                     ((state_q == S_HOLD) & redirect);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (xfer_evt && (perf_fetched_q != '1))  perf_fetched_q <= perf_fetched_q + 32'd1;
      if (flush_evt && (perf_flushed_q != '1)) perf_flushed_q <= perf_flushed_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // DUT A: RESET_PC = 0
  logic        fe_a, br_a, ub_a, z_a;
  logic [63:0] np_a, pc_a;
  // DUT B: RESET_PC at the top of the address space, for the wrap check
  logic        fe_b, br_b, ub_b, z_b;
  logic [63:0] np_b, pc_b;

  fetch_controller_if bus_a ();
  fetch_controller_if bus_b ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pf_a, pfl_a, pf_b, pfl_b;
`endif

  fetch_controller #(
    .RESET_PC (64'h0),
    .PC_STEP  (64'd4)
  ) u_a (
    .clk                (clk),
    .reset              (reset),
    .fetch_en           (fe_a),
    .branch_flag        (br_a),
    .uncond_branch_flag (ub_a),
    .zero_flag          (z_a),
    .new_pc             (np_a),
    .bus                (bus_a.master),
    .pc                 (pc_a)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched       (pf_a),
    .perf_flushed       (pfl_a)
`endif
  );

  fetch_controller #(
    .RESET_PC (64'hFFFF_FFFF_FFFF_FFFC),
    .PC_STEP  (64'd4)
  ) u_b (
    .clk                (clk),
    .reset              (reset),
    .fetch_en           (fe_b),
    .branch_flag        (br_b),
    .uncond_branch_flag (ub_b),
    .zero_flag          (z_b),
    .new_pc             (np_b),
    .bus                (bus_b.master),
    .pc                 (pc_b)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched       (pf_b),
    .perf_flushed       (pfl_b)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [31:0] inst;
    logic [63:0] ipc;
    logic [63:0] pc;
  } outs_t;

  typedef struct {
    logic        fe, ack;
    logic [31:0] data;
    logic        rdy, br, z, ub;
    logic [63:0] npc;
    outs_t       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic outs_t mk_out(input logic req, input logic [63:0] addr, input logic valid,
                                   input logic [31:0] inst, input logic [63:0] ipc);
    outs_t o;
    o.req = req; o.addr = addr; o.valid = valid; o.inst = inst; o.ipc = ipc;
    o.pc = addr;
    return o;
  endfunction

  function automatic vec_t mk(input logic fe, input logic ack, input logic [31:0] data,
                              input logic rdy, input logic br, input logic z, input logic ub,
                              input logic [63:0] npc, input outs_t exp);
    vec_t v;
    v.fe = fe; v.ack = ack; v.data = data; v.rdy = rdy;
    v.br = br; v.z = z; v.ub = ub; v.npc = npc; v.exp = exp;
    return v;
  endfunction

  function automatic outs_t sample_a();
    outs_t o;
    o.req = bus_a.imem_req; o.addr = bus_a.imem_addr; o.valid = bus_a.inst_valid;
    o.inst = bus_a.inst; o.ipc = bus_a.inst_pc; o.pc = pc_a;
    return o;
  endfunction

  function automatic outs_t sample_b();
    outs_t o;
    o.req = bus_b.imem_req; o.addr = bus_b.imem_addr; o.valid = bus_b.inst_valid;
    o.inst = bus_b.inst; o.ipc = bus_b.inst_pc; o.pc = pc_b;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_outs(input string tag, input outs_t act, input outs_t exp);
    chk({tag, ".imem_req"},   64'(act.req),   64'(exp.req));
    chk({tag, ".imem_addr"},  act.addr,       exp.addr);
    chk({tag, ".inst_valid"}, 64'(act.valid), 64'(exp.valid));
    chk({tag, ".inst"},       64'(act.inst),  64'(exp.inst));
    chk({tag, ".inst_pc"},    act.ipc,        exp.ipc);
    chk({tag, ".pc"},         act.pc,         exp.pc);
  endtask

  task automatic drive_a(input logic fe, input logic ack, input logic [31:0] data, input logic rdy,
                         input logic br, input logic z, input logic ub, input logic [63:0] npc);
    fe_a = fe; bus_a.imem_ack = ack; bus_a.imem_data = data; bus_a.dec_ready = rdy;
    br_a = br; z_a = z; ub_a = ub; np_a = npc;
  endtask

  task automatic drive_b(input logic fe, input logic ack, input logic [31:0] data, input logic rdy);
    fe_b = fe; bus_b.imem_ack = ack; bus_b.imem_data = data; bus_b.dec_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model of DUT A, phrased as "is a request outstanding" /
  // "is an instruction waiting for decode" plus the pending redirect.
  logic        m_req, m_hold, m_kill;
  logic [63:0] m_pc, m_redir, m_ipc;
  logic [31:0] m_inst;
  int          m_fetched, m_flushed;

  task automatic model_reset();
    m_req = 0; m_hold = 0; m_kill = 0;
    m_pc = 64'h0; m_redir = 64'h0; m_ipc = 64'h0; m_inst = 32'h0;
    m_fetched = 0; m_flushed = 0;
  endtask

  task automatic model_step(input logic fe, input logic ack, input logic [31:0] data, input logic rdy,
                            input logic br, input logic z, input logic ub, input logic [63:0] npc);
    logic        redir;
    logic [63:0] tgt;
    redir = (br && z) || ub;
    tgt   = {npc[63:2], 2'b00};
    if (m_hold) begin
      if (redir) begin
        m_hold = 0; m_pc = tgt; m_req = fe; m_flushed++;
      end else if (rdy) begin
        m_hold = 0; m_req = fe; m_fetched++;
      end
    end else if (m_req) begin
      if (ack) begin
        if (m_kill || redir) begin
          m_pc = redir ? tgt : m_redir;
          m_kill = 0; m_req = fe; m_flushed++;
        end else begin
          m_inst = data; m_ipc = m_pc; m_pc = m_pc + 64'd4;
          m_hold = 1; m_req = 0;
        end
      end else if (redir) begin
        m_kill = 1; m_redir = tgt;
      end
    end else begin
      if (redir) m_pc = tgt;
      m_req = fe;
    end
  endtask

  initial begin
    outs_t reset_a;
    reset = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    br_b = 0; z_b = 0; ub_b = 0; np_b = 64'h0;
    reset_a = mk_out(0, 64'h0, 0, 32'h0, 64'h0);

    // ---------------- directed vector table (DUT A) ----------------
    tbl.push_back(mk(1,0,32'h0,        0,0,0,0,64'h0,   mk_out(1,64'h0,  0,32'h0,        64'h0)));
    tbl.push_back(mk(1,1,32'hA000_0000,0,0,0,0,64'h0,   mk_out(0,64'h4,  1,32'hA000_0000,64'h0)));
    tbl.push_back(mk(1,0,32'h0,        1,0,0,0,64'h0,   mk_out(1,64'h4,  0,32'hA000_0000,64'h0)));
    tbl.push_back(mk(1,1,32'hA000_0001,0,0,0,0,64'h0,   mk_out(0,64'h8,  1,32'hA000_0001,64'h4)));
    tbl.push_back(mk(1,0,32'h0,        1,0,0,0,64'h0,   mk_out(1,64'h8,  0,32'hA000_0001,64'h4)));
    tbl.push_back(mk(1,1,32'hA000_0002,0,0,0,0,64'h0,   mk_out(0,64'hC,  1,32'hA000_0002,64'h8)));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,32'h0,      0,0,0,0,64'h0,   mk_out(0,64'hC,  1,32'hA000_0002,64'h8)));
    tbl.push_back(mk(1,0,32'h0,        1,0,0,0,64'h0,   mk_out(1,64'hC,  0,32'hA000_0002,64'h8)));
    tbl.push_back(mk(1,0,32'h0,        0,0,0,1,64'h103, mk_out(1,64'hC,  0,32'hA000_0002,64'h8)));
    tbl.push_back(mk(1,1,32'hBAD0_BAD0,0,0,0,0,64'h0,   mk_out(1,64'h100,0,32'hA000_0002,64'h8)));
    tbl.push_back(mk(1,1,32'hB000_0000,0,0,0,0,64'h0,   mk_out(0,64'h104,1,32'hB000_0000,64'h100)));
    tbl.push_back(mk(1,0,32'h0,        1,1,1,0,64'h200, mk_out(1,64'h200,0,32'hB000_0000,64'h100)));
    tbl.push_back(mk(1,1,32'hC000_0000,0,0,0,0,64'h0,   mk_out(0,64'h204,1,32'hC000_0000,64'h200)));
    tbl.push_back(mk(1,0,32'h0,        0,1,0,0,64'h300, mk_out(0,64'h204,1,32'hC000_0000,64'h200)));
    tbl.push_back(mk(0,0,32'h0,        1,0,0,0,64'h0,   mk_out(0,64'h204,0,32'hC000_0000,64'h200)));
    tbl.push_back(mk(0,0,32'h0,        0,0,0,1,64'h3F7, mk_out(0,64'h3F4,0,32'hC000_0000,64'h200)));
    tbl.push_back(mk(1,1,32'hDEAD_DEAD,0,0,0,0,64'h0,   mk_out(1,64'h3F4,0,32'hC000_0000,64'h200)));
    tbl.push_back(mk(0,0,32'h0,        0,0,0,0,64'h0,   mk_out(1,64'h3F4,0,32'hC000_0000,64'h200)));
    tbl.push_back(mk(0,1,32'hD000_0000,0,0,0,0,64'h0,   mk_out(0,64'h3F8,1,32'hD000_0000,64'h3F4)));
    tbl.push_back(mk(0,0,32'h0,        1,0,0,0,64'h0,   mk_out(0,64'h3F8,0,32'hD000_0000,64'h3F4)));
    tbl.push_back(mk(1,0,32'h0,        0,0,0,0,64'h0,   mk_out(1,64'h3F8,0,32'hD000_0000,64'h3F4)));
    tbl.push_back(mk(1,1,32'hE000_0000,0,0,0,1,64'h500, mk_out(1,64'h500,0,32'hD000_0000,64'h3F4)));
    tbl.push_back(mk(1,1,32'hE000_0001,0,0,0,0,64'h0,   mk_out(0,64'h504,1,32'hE000_0001,64'h500)));
    tbl.push_back(mk(0,0,32'h0,        1,0,0,0,64'h0,   mk_out(0,64'h504,0,32'hE000_0001,64'h500)));

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_outs("reset_a", sample_a(), reset_a);
    cmp_outs("reset_b", sample_b(), mk_out(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 64'h0));
`ifdef FETCH_PERF_CNT_EN
    chk("reset.perf_fetched", 64'(pf_a), 64'h0);
    chk("reset.perf_flushed", 64'(pfl_a), 64'h0);
`endif

    foreach (tbl[i]) begin
      drive_a(tbl[i].fe, tbl[i].ack, tbl[i].data, tbl[i].rdy,
              tbl[i].br, tbl[i].z, tbl[i].ub, tbl[i].npc);
      step();
      cmp_outs($sformatf("row%0d", i), sample_a(), tbl[i].exp);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("tbl.perf_fetched", 64'(pf_a), 64'd6);
    chk("tbl.perf_flushed", 64'(pfl_a), 64'd3);
`endif

    // ---------------- ack delayed 3 cycles ----------------
    drive_a(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    cmp_outs("lat.req0", sample_a(), mk_out(1, 64'h504, 0, 32'hE000_0001, 64'h500));
    for (int k = 1; k <= 3; k++) begin
      step();
      cmp_outs($sformatf("lat.req%0d", k), sample_a(), mk_out(1, 64'h504, 0, 32'hE000_0001, 64'h500));
    end
    drive_a(0, 1, 32'hF000_0000, 0, 0, 0, 0, 0);
    step();
    cmp_outs("lat.ack", sample_a(), mk_out(0, 64'h508, 1, 32'hF000_0000, 64'h504));
    drive_a(0, 0, 0, 1, 0, 0, 0, 0);
    step();
    cmp_outs("lat.xfer", sample_a(), mk_out(0, 64'h508, 0, 32'hF000_0000, 64'h504));
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- PC wrap (DUT B) ----------------
    drive_b(1, 0, 0, 0);
    step();
    cmp_outs("wrap.req", sample_b(), mk_out(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 64'h0));
    drive_b(1, 1, 32'h1111_1111, 0);
    step();
    cmp_outs("wrap.ack", sample_b(), mk_out(0, 64'h0, 1, 32'h1111_1111, 64'hFFFF_FFFF_FFFF_FFFC));
    drive_b(1, 0, 0, 1);
    step();
    cmp_outs("wrap.xfer", sample_b(), mk_out(1, 64'h0, 0, 32'h1111_1111, 64'hFFFF_FFFF_FFFF_FFFC));
    drive_b(0, 1, 32'h2222_2222, 0);
    step();
    cmp_outs("wrap.ack2", sample_b(), mk_out(0, 64'h4, 1, 32'h2222_2222, 64'h0));
    drive_b(0, 0, 0, 0);

    // ---------------- reset mid-request, then stray ack ----------------
    drive_a(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("rst.pre_req", 64'(bus_a.imem_req), 64'h1);
    #2 reset = 1'b1;
    #1;
    cmp_outs("rst.async", sample_a(), reset_a);
`ifdef FETCH_PERF_CNT_EN
    chk("rst.perf_fetched", 64'(pf_a), 64'h0);
    chk("rst.perf_flushed", 64'(pfl_a), 64'h0);
`endif
    #1 reset = 1'b0;
    drive_a(0, 1, 32'hBEEF_BEEF, 0, 0, 0, 0, 0);
    step();
    cmp_outs("rst.stray_ack", sample_a(), reset_a);
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);

    // ---------------- randomized run against the reference model ----------------
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic        fe, ack, rdy, br, z, ub;
      logic [31:0] data;
      logic [63:0] npc;
      cmp_outs($sformatf("rnd%0d", cyc), sample_a(), mk_out(m_req, m_pc, m_hold, m_inst, m_ipc));
      fe   = ($urandom_range(0, 7) != 0);
      rdy  = ($urandom_range(0, 2) != 0);
      ack  = m_req ? ($urandom_range(0, 2) == 0) : (!m_hold && ($urandom_range(0, 9) == 0));
      data = $urandom;
      br   = ($urandom_range(0, 4) == 0);
      z    = 1'($urandom_range(0, 1));
      ub   = ($urandom_range(0, 11) == 0);
      npc  = {$urandom, $urandom};
      drive_a(fe, ack, data, rdy, br, z, ub, npc);
      model_step(fe, ack, data, rdy, br, z, ub, npc);
      step();
    end
    cmp_outs("rnd.final", sample_a(), mk_out(m_req, m_pc, m_hold, m_inst, m_ipc));
`ifdef FETCH_PERF_CNT_EN
    chk("rnd.perf_fetched", 64'(pf_a), 64'(m_fetched));
    chk("rnd.perf_flushed", 64'(pfl_a), 64'(m_flushed));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
